// File: rtl/hmac_drbg_pkg.sv
// Shared definitions for the hmac_drbg seed/nonce sequencer: default sizes,
// sequencer state encoding and DRBG mode encodings.
package hmac_drbg_pkg;

   localparam int unsigned SEED_SIZE_DEF       = 32'd384;
   localparam int unsigned REG_SIZE_DEF        = 32'd384;
   localparam int unsigned WORD_W_DEF          = 32'd32;
   localparam int unsigned RESEED_INTERVAL_DEF = 32'd16;

   // Number of entropy words that make up one seed at the default sizes.
   localparam int unsigned SEED_WORDS = SEED_SIZE_DEF / WORD_W_DEF;

   // DRBG request modes.
   localparam logic MODE_RAND = 1'b0;
   localparam logic MODE_DET  = 1'b1;

   // Sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COLLECT   = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_WAIT_BUSY = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_HOLD      = 3'd5
   } seed_ctrl_state_e;

   // Bits needed for a counter that must hold values 0..max_val (at least 1 bit).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      if (max_val < 32'd2) begin
         w = 32'd1;
      end else begin
         w = $clog2(max_val + 32'd1);
      end
      return w;
   endfunction

endpackage

// File: rtl/hmac_drbg_seed_ctrl.sv
// Seed/nonce sequencer sitting directly upstream of hmac_drbg. Gathers entropy
// into the seed register, pulses the DRBG init/next controls, keeps seed and
// mode stable while the DRBG runs, and hands the resulting nonce to the consumer.
// Random-mode requests are forced to reseed after RESEED_INTERVAL nexts.
module hmac_drbg_seed_ctrl
   import hmac_drbg_pkg::*;
#(
   parameter int unsigned SEED_SIZE       = SEED_SIZE_DEF,
   parameter int unsigned REG_SIZE        = REG_SIZE_DEF,
   parameter int unsigned WORD_W          = WORD_W_DEF,
   parameter int unsigned RESEED_INTERVAL = RESEED_INTERVAL_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 zeroize,
   input  logic                 req_i,
   input  logic                 req_mode_i,
   output logic                 req_ready_o,
   input  logic                 ent_valid_i,
   input  logic [WORD_W-1:0]    ent_data_i,
   output logic                 ent_ready_o,
   output logic                 drbg_mode_o,
   output logic                 drbg_init_o,
   output logic                 drbg_next_o,
   output logic [SEED_SIZE-1:0] drbg_seed_o,
   input  logic                 drbg_ready_i,
   input  logic                 drbg_valid_i,
   input  logic [REG_SIZE-1:0]  drbg_nonce_i,
   output logic                 nonce_valid_o,
   output logic [REG_SIZE-1:0]  nonce_o,
   input  logic                 nonce_ready_i
);

   localparam int unsigned N_WORDS = SEED_SIZE / WORD_W;
   localparam int unsigned WC_W    = cnt_width(N_WORDS - 32'd1);
   localparam int unsigned GEN_W   = cnt_width(RESEED_INTERVAL);

   localparam logic [WC_W-1:0]  WC_LAST = WC_W'(N_WORDS - 32'd1);
   localparam logic [GEN_W-1:0] GEN_MAX = GEN_W'(RESEED_INTERVAL);

   seed_ctrl_state_e     state_q, state_d;
   logic                 mode_q, mode_d;
   logic                 issue_init_q, issue_init_d;
   logic                 seeded_q, seeded_d;
   logic [WC_W-1:0]      word_cnt_q, word_cnt_d;
   logic [GEN_W-1:0]     gen_cnt_q, gen_cnt_d;
   logic [SEED_SIZE-1:0] seed_q, seed_d;
   logic [REG_SIZE-1:0]  nonce_q, nonce_d;
   logic                 clear_s;

   // Reset and zeroize share one clear path; it overrides every handshake.
   assign clear_s = reset | zeroize;

   // Seed and mode go straight from their registers so they stay put for the DRBG run.
   assign drbg_mode_o = mode_q;
   assign drbg_seed_o = seed_q;

   // Next-state, datapath updates and handshake/pulse outputs.
   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      issue_init_d  = issue_init_q;
      seeded_d      = seeded_q;
      word_cnt_d    = word_cnt_q;
      gen_cnt_d     = gen_cnt_q;
      seed_d        = seed_q;
      nonce_d       = nonce_q;
      req_ready_o   = 1'b0;
      ent_ready_o   = 1'b0;
      drbg_init_o   = 1'b0;
      drbg_next_o   = 1'b0;
      nonce_valid_o = 1'b0;
      nonce_o       = '0;

      if (clear_s) begin
         state_d      = ST_IDLE;
         mode_d       = MODE_RAND;
         issue_init_d = 1'b0;
         seeded_d     = 1'b0;
         word_cnt_d   = '0;
         gen_cnt_d    = '0;
         seed_d       = '0;
         nonce_d      = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               req_ready_o = 1'b1;
               if (req_i) begin
                  mode_d = req_mode_i;
                  if (req_mode_i == MODE_DET) begin
                     issue_init_d = 1'b1;
                     state_d      = ST_ISSUE;
                  end else if (!seeded_q || (gen_cnt_q == GEN_MAX)) begin
                     word_cnt_d = '0;
                     state_d    = ST_COLLECT;
                  end else begin
                     issue_init_d = 1'b0;
                     state_d      = ST_ISSUE;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end

            ST_COLLECT: begin
               ent_ready_o = 1'b1;
               if (ent_valid_i) begin
                  // Shift left so the first word ends up in the top slot.
                  seed_d = {seed_q[SEED_SIZE-WORD_W-1:0], ent_data_i};
                  if (word_cnt_q == WC_LAST) begin
                     word_cnt_d   = '0;
                     seeded_d     = 1'b1;
                     gen_cnt_d    = '0;
                     issue_init_d = 1'b1;
                     state_d      = ST_ISSUE;
                  end else begin
                     word_cnt_d = word_cnt_q + {{(WC_W-1){1'b0}}, 1'b1};
                  end
               end else begin
                  state_d = ST_COLLECT;
               end
            end

            ST_ISSUE: begin
               if (drbg_ready_i) begin
                  if (issue_init_q) begin
                     drbg_init_o = 1'b1;
                  end else begin
                     drbg_next_o = 1'b1;
                     if ((mode_q == MODE_RAND) && (gen_cnt_q < GEN_MAX)) begin
                        gen_cnt_d = gen_cnt_q + {{(GEN_W-1){1'b0}}, 1'b1};
                     end else begin
                        gen_cnt_d = gen_cnt_q;
                     end
                  end
                  state_d = ST_WAIT_BUSY;
               end else begin
                  state_d = ST_ISSUE;
               end
            end

            ST_WAIT_BUSY: begin
               // A valid still high from the previous run must not be taken as ours.
               if (!drbg_ready_i) begin
                  state_d = ST_WAIT_DONE;
               end else begin
                  state_d = ST_WAIT_BUSY;
               end
            end

            ST_WAIT_DONE: begin
               if (drbg_ready_i && drbg_valid_i) begin
                  nonce_d = drbg_nonce_i;
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_WAIT_DONE;
               end
            end

            ST_HOLD: begin
               nonce_valid_o = 1'b1;
               nonce_o       = nonce_q;
               if (nonce_ready_i) begin
                  nonce_d = '0;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HOLD;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_RAND;
         issue_init_q <= 1'b0;
         seeded_q     <= 1'b0;
         word_cnt_q   <= '0;
         gen_cnt_q    <= '0;
         seed_q       <= '0;
         nonce_q      <= '0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         issue_init_q <= issue_init_d;
         seeded_q     <= seeded_d;
         word_cnt_q   <= word_cnt_d;
         gen_cnt_q    <= gen_cnt_d;
         seed_q       <= seed_d;
         nonce_q      <= nonce_d;
      end
   end

endmodule

// File: tb/tb_hmac_drbg_seed_ctrl.sv
// Self-checking bench for hmac_drbg_seed_ctrl: a transaction-level model of the
// sequencer plus a small behavioural hmac_drbg, checked on every cycle, with
// directed scenarios followed by randomized traffic.
module tb_hmac_drbg_seed_ctrl;

   localparam int SS = 384;
   localparam int RS = 384;
   localparam int WW = 32;
   localparam int RI = 2;
   localparam int NW = SS / WW;

   // Model phases: what the sequencer is doing at transaction level.
   localparam int P_IDLE  = 0;
   localparam int P_COLL  = 1;
   localparam int P_ISSUE = 2;
   localparam int P_RUN   = 3;
   localparam int P_HOLD  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          zeroize = 1'b0;
   logic          req_i = 1'b0;
   logic          req_mode_i = 1'b0;
   logic          req_ready_o;
   logic          ent_valid_i = 1'b0;
   logic [WW-1:0] ent_data_i = '0;
   logic          ent_ready_o;
   logic          drbg_mode_o;
   logic          drbg_init_o;
   logic          drbg_next_o;
   logic [SS-1:0] drbg_seed_o;
   logic          drbg_ready_i = 1'b1;
   logic          drbg_valid_i = 1'b0;
   logic [RS-1:0] drbg_nonce_i = '0;
   logic          nonce_valid_o;
   logic [RS-1:0] nonce_o;
   logic          nonce_ready_i = 1'b0;

   always #5 clk = ~clk;

   hmac_drbg_seed_ctrl #(
      .SEED_SIZE(SS), .REG_SIZE(RS), .WORD_W(WW), .RESEED_INTERVAL(RI)
   ) dut (
      .clk(clk), .reset(reset), .zeroize(zeroize),
      .req_i(req_i), .req_mode_i(req_mode_i), .req_ready_o(req_ready_o),
      .ent_valid_i(ent_valid_i), .ent_data_i(ent_data_i), .ent_ready_o(ent_ready_o),
      .drbg_mode_o(drbg_mode_o), .drbg_init_o(drbg_init_o), .drbg_next_o(drbg_next_o),
      .drbg_seed_o(drbg_seed_o), .drbg_ready_i(drbg_ready_i), .drbg_valid_i(drbg_valid_i),
      .drbg_nonce_i(drbg_nonce_i), .nonce_valid_o(nonce_valid_o), .nonce_o(nonce_o),
      .nonce_ready_i(nonce_ready_i)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Sequencer model
   int            ph = P_IDLE;
   bit            m_seeded = 1'b0;
   int            m_gen = 0;
   int            m_words = 0;
   logic [WW-1:0] m_wq [NW];
   logic [SS-1:0] m_seed = '0;
   bit            m_mode = 1'b0;
   bit            m_init = 1'b0;
   logic [RS-1:0] m_nonce = '0;

   // Behavioural DRBG model
   bit            d_ready = 1'b1;
   bit            d_valid = 1'b0;
   logic [RS-1:0] d_nonce = '0;
   bit            d_active = 1'b0;
   bit            d_fresh = 1'b0;
   int            d_pre = 0;
   int            d_busy = 0;

   logic [SS-1:0] seed_lit;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkw(input string name, input logic [SS-1:0] act, input logic [SS-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [RS-1:0] rand_wide();
      logic [RS-1:0] v;
      for (int i = 0; i < RS / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // DRBG: after a command it may keep ready (and the stale valid) high for a
   // few cycles, then goes busy, then returns ready+valid with a new nonce.
   task automatic drbg_advance(input bit pulse);
      if (pulse) begin
         d_active = 1'b1;
         d_fresh  = 1'b0;
         d_pre    = $urandom_range(0, 2);
         d_busy   = $urandom_range(1, 4);
      end
      if (d_active) begin
         if (d_pre > 0) begin
            d_pre--;
            d_ready = 1'b1;
         end else if (d_busy > 0) begin
            d_busy--;
            d_ready = 1'b0;
            d_valid = 1'b0;
            d_nonce = rand_wide();
         end else begin
            d_ready  = 1'b1;
            d_valid  = 1'b1;
            d_nonce  = rand_wide();
            d_fresh  = 1'b1;
            d_active = 1'b0;
         end
      end
   endtask

   // One clock cycle: drive inputs, check every output against the model, advance the model.
   task automatic step(input bit rst, input bit zz, input bit r, input bit rm,
                       input bit ev, input logic [WW-1:0] ed, input bit nr);
      bit clr, e_pulse;
      @(negedge clk);
      reset = rst; zeroize = zz; req_i = r; req_mode_i = rm;
      ent_valid_i = ev; ent_data_i = ed; nonce_ready_i = nr;
      drbg_ready_i = d_ready; drbg_valid_i = d_valid; drbg_nonce_i = d_nonce;
      #1;
      clr     = rst | zz;
      e_pulse = !clr && (ph == P_ISSUE) && d_ready;
      chk1("req_ready", req_ready_o, !clr && (ph == P_IDLE));
      chk1("ent_ready", ent_ready_o, !clr && (ph == P_COLL));
      chk1("nonce_valid", nonce_valid_o, !clr && (ph == P_HOLD));
      chkw("nonce", nonce_o, (!clr && (ph == P_HOLD)) ? m_nonce : '0);
      chk1("init_pulse", drbg_init_o, e_pulse && m_init);
      chk1("next_pulse", drbg_next_o, e_pulse && !m_init);
      if (!clr && (ph == P_ISSUE || ph == P_RUN || ph == P_HOLD)) begin
         chkw("seed_stable", drbg_seed_o, m_seed);
         chk1("mode_stable", drbg_mode_o, m_mode);
      end
      if (clr) begin
         ph = P_IDLE; m_seeded = 1'b0; m_gen = 0; m_seed = '0;
         m_mode = 1'b0; m_init = 1'b0; m_nonce = '0;
      end else begin
         case (ph)
            P_IDLE: if (r) begin
               m_mode = rm;
               if (rm) begin
                  m_init = 1'b1; ph = P_ISSUE;
               end else if (!m_seeded || m_gen == RI) begin
                  m_words = 0; ph = P_COLL;
               end else begin
                  m_init = 1'b0; ph = P_ISSUE;
               end
            end
            P_COLL: if (ev) begin
               m_wq[m_words] = ed;
               m_words++;
               if (m_words == NW) begin
                  for (int i = 0; i < NW; i++) m_seed[SS-1-WW*i -: WW] = m_wq[i];
                  m_seeded = 1'b1; m_gen = 0; m_init = 1'b1; ph = P_ISSUE;
               end
            end
            P_ISSUE: if (d_ready) begin
               if (!m_init && !m_mode && m_gen < RI) m_gen++;
               ph = P_RUN;
            end
            P_RUN: if (d_ready && d_valid && d_fresh) begin
               m_nonce = d_nonce; ph = P_HOLD;
            end
            P_HOLD: if (nr) ph = P_IDLE;
            default: ph = P_IDLE;
         endcase
      end
      drbg_advance(e_pulse);
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic wait_nonce(input string name);
      int k = 0;
      while (!nonce_valid_o && k < 40) begin
         idle_step();
         k++;
      end
      chk1(name, nonce_valid_o, 1'b1);
   endtask

   initial begin
      int nacc;
      for (int i = 0; i < NW; i++) seed_lit[SS-1-WW*i -: WW] = WW'(i);

      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      idle_step();
      chk1("lit_req_ready_after_reset", req_ready_o, 1'b1);
      chkw("lit_seed_after_reset", drbg_seed_o, '0);

      // Fresh random-mode request: 12 words 0..B, then init.
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < NW; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WW'(i), 1'b0);
      idle_step();
      chk1("lit_first_init", drbg_init_o, 1'b1);
      chkw("lit_seed_words", drbg_seed_o, seed_lit);
      chkw("lit_model_seed", m_seed, seed_lit);
      wait_nonce("lit_nonce1_timeout");
      chkw("lit_nonce1_value", nonce_o, d_nonce);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

      // Two nexts allowed, then a forced reseed.
      for (int j = 0; j < 2; j++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
         idle_step();
         chk1("lit_next_one_cycle", drbg_next_o, 1'b1);
         wait_nonce("lit_next_nonce_timeout");
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      idle_step();
      chk1("lit_reseed_collect", ent_ready_o, 1'b1);

      // Zeroize part-way through collection; the concurrent word is dropped.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, $urandom, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, $urandom, 1'b0);
      idle_step();
      chk1("lit_idle_after_zeroize", req_ready_o, 1'b1);
      chkw("lit_seed_zeroized", drbg_seed_o, '0);

      // Deterministic request while unseeded: init, no entropy.
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, $urandom, 1'b0);
      idle_step();
      chk1("lit_det_init", drbg_init_o, 1'b1);
      chk1("lit_det_no_entropy", ent_ready_o, 1'b0);
      wait_nonce("lit_det_nonce_timeout");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      idle_step();
      chkw("lit_nonce_zero_after_zeroize", nonce_o, '0);
      chk1("lit_idle_after_hold_zeroize", req_ready_o, 1'b1);

      // Next random request must recollect all 12 words.
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      nacc = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, $urandom, 1'b0);
         if (ent_ready_o) nacc++;
      end
      chkw("lit_recollect_words", SS'(nacc), SS'(NW));
      wait_nonce("lit_recollect_nonce_timeout");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         step(($urandom % 700) == 0, ($urandom % 150) == 0, ($urandom % 4) == 0,
              ($urandom % 4) == 0, ($urandom % 3) != 0, $urandom, ($urandom % 2) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
